// File: rtl/lms_sample_driver_pkg.sv
// lms_sample_driver_pkg: shared types for the LMS sample driver.
// Holds the FSM state encoding and the {ref, mic} sample-pair type.
package lms_sample_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  typedef struct packed {
    logic signed [15:0] ref_smp;
    logic signed [15:0] mic_smp;
  } pair_t;

  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/lms_pair_fifo.sv
// lms_pair_fifo: sample-pair FIFO, DEPTH entries, sync active-high rst.
// Ports: push/din in, pop/dout out (show-ahead), full, empty.
module lms_pair_fifo
  import lms_sample_driver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  pair_t din,
  output pair_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;
  pair_t         mem_q [DEPTH];

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a
  // full FIFO still accepts a push alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = nxt(wr_ptr_q);
    if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lms_sample_driver.sv
// lms_sample_driver: feeds buffered ADC pairs to an LMS filter one at
// a time, waits LATENCY cycles, then presents the result to a DAC.
// Ports: clk, rst (sync, active-high); adc_valid/adc_ref/adc_mic in;
// filter_in/filter_en/desired_in/desired_en out; filter_out/error_out
// in; dac_valid/dac_err/dac_est out, dac_ready in; busy, fifo_full.
// Macro LMS_DROP_CNT_EN adds drop_cnt (saturating discard counter).
module lms_sample_driver
  import lms_sample_driver_pkg::*;
#(
  parameter int unsigned STAGE      = 256,
  parameter int unsigned LATENCY    = STAGE + 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adc_valid,
  input  logic signed [15:0] adc_ref,
  input  logic signed [15:0] adc_mic,
  output logic signed [15:0] filter_in,
  output logic               filter_en,
  output logic signed [15:0] desired_in,
  output logic               desired_en,
  input  logic signed [15:0] filter_out,
  input  logic signed [15:0] error_out,
  output logic               dac_valid,
  input  logic               dac_ready,
  output logic signed [15:0] dac_err,
  output logic signed [15:0] dac_est,
  output logic               busy,
  output logic               fifo_full
`ifdef LMS_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  if (STAGE == 0) begin : g_chk_stage
    $error("STAGE must be nonzero");
  end
  if (LATENCY < 2) begin : g_chk_lat
    $error("LATENCY must be at least 2");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_dep
    $error("FIFO_DEPTH must be a power of two");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [15:0] fin_q, fin_d;
  logic signed [15:0] din_q, din_d;
  logic signed [15:0] err_q, err_d;
  logic signed [15:0] est_q, est_d;
  logic               fifo_pop;
  logic               fifo_empty;
  pair_t              fifo_dout;
  pair_t              fifo_din;

  assign fifo_din = '{ref_smp: adc_ref, mic_smp: adc_mic};

  lms_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (adc_valid),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // filter_in/desired_in load from the FIFO head on entry to
  // ISSUE, so they are valid for the whole filter_en cycle;
  // the head is then popped at the end of ISSUE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    din_d    = din_q;
    err_d    = err_q;
    est_d    = est_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ISSUE;
          fin_d   = fifo_dout.ref_smp;
          din_d   = fifo_dout.mic_smp;
        end
      end
      ST_ISSUE: begin
        fifo_pop = 1'b1;
        cnt_d    = CNT_W'(1);
        state_d  = ST_WAIT;
      end
      // cnt counts cycles since ISSUE; CAPTURE lands
      // exactly LATENCY cycles after the filter_en cycle.
      ST_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        err_d   = error_out;
        est_d   = filter_out;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (dac_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fin_q   <= '0;
      din_q   <= '0;
      err_q   <= '0;
      est_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      din_q   <= din_d;
      err_q   <= err_d;
      est_q   <= est_d;
    end
  end

  assign filter_in  = fin_q;
  assign desired_in = din_q;
  assign dac_err    = err_q;
  assign dac_est    = est_q;
  assign filter_en  = (state_q == ST_ISSUE);
  assign desired_en = (state_q == ST_ISSUE);
  assign dac_valid  = (state_q == ST_OUT);
  assign busy       = (state_q != ST_IDLE);

`ifdef LMS_DROP_CNT_EN
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  assign drop = adc_valid && fifo_full && !fifo_pop;

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: doc/lms_sample_driver.md
LMS_SAMPLE_DRIVER -- requirements
Module: lms_sample_driver

Interface
REQ-001 SHALL have parameter STAGE, default 256: tap count of the downstream adaptive filter.
REQ-002 SHALL have parameter LATENCY, default STAGE+12: cycles from filter_en pulse until filter_out/error_out are valid.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two: input sample-pair buffer depth.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-005 SHALL have ports: adc_valid in 1 (one-cycle strobe, new ADC pair); adc_ref in 16 signed (reference/noise); adc_mic in 16 signed (microphone/desired).
REQ-006 SHALL have ports: filter_in out 16 signed; filter_en out 1; desired_in out 16 signed; desired_en out 1; filter_out in 16 signed; error_out in 16 signed.
REQ-007 SHALL have ports: dac_valid out 1; dac_ready in 1; dac_err out 16 signed; dac_est out 16 signed; busy out 1; fifo_full out 1.

Function
REQ-008 SHALL push {adc_ref, adc_mic} into the FIFO on adc_valid when not full.
REQ-009 SHALL discard the incoming pair on adc_valid while full; FIFO contents unchanged.
REQ-010 SHALL run FSM states IDLE, ISSUE, WAIT, CAPTURE, OUT.
REQ-011 IDLE->ISSUE when FIFO non-empty; otherwise stay in IDLE.
REQ-012 ISSUE: pop one pair; drive filter_in=ref, desired_in=mic; assert filter_en and desired_en together for exactly one cycle; then go to WAIT.
REQ-013 filter_in/desired_in SHALL hold the issued values until the next ISSUE.
REQ-014 WAIT: count LATENCY cycles from the ISSUE cycle, then go to CAPTURE.
REQ-015 CAPTURE: register error_out->dac_err and filter_out->dac_est; go to OUT.
REQ-016 OUT: assert dac_valid with dac_err/dac_est stable until dac_ready is high on a clock edge; on that edge deassert dac_valid and go to IDLE.
REQ-017 filter_en SHALL never pulse again before the previous result is captured (one sample in flight).
REQ-018 busy SHALL be high in every state except IDLE.
REQ-019 Push and pop in the same cycle SHALL both succeed; occupancy unchanged.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 fifo_full SHALL be high exactly when occupancy equals FIFO_DEPTH.
REQ-022 Sample order SHALL be preserved end to end: dac output order equals adc_valid acceptance order.

Reset
REQ-023 rst SHALL force state IDLE, FIFO empty, WAIT counter 0.
REQ-024 rst SHALL drive filter_en, desired_en, dac_valid, busy, fifo_full to 0, and filter_in, desired_in, dac_err, dac_est to 0.
REQ-025 rst asserted mid-WAIT or mid-OUT SHALL abandon the in-flight sample with no dac_valid pulse.
REQ-026 rst SHALL take priority over a simultaneous adc_valid.

Configuration
REQ-027 Macro LMS_DROP_CNT_EN defined: SHALL add output drop_cnt, 16 bits, counting pairs discarded per REQ-009, saturating at 0xFFFF, cleared by rst.
REQ-028 Macro LMS_DROP_CNT_EN undefined: SHALL have no drop_cnt port and no counter logic; discards are silent.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding constants and the 32-bit sample-pair typedef {ref, mic}.
REQ-030 The FIFO SHALL be a separate sub-module, lms_pair_fifo (push, pop, full, empty).
REQ-031 FSM, counter and output registers SHALL reside in lms_sample_driver.

Verification
REQ-032 Single pair: adc_valid with ref=0x1000, mic=0x0800 -> one filter_en/desired_en pulse with those values; next filter_en no earlier than LATENCY cycles later; dac_valid with dac_err=error_out sampled at CAPTURE.
REQ-033 Burst: 6 adc_valid pulses back to back while busy, FIFO_DEPTH=4 -> first sample issued, next 4 buffered, 6th dropped, fifo_full high during drop; with LMS_DROP_CNT_EN, drop_cnt=1.
REQ-034 Backpressure: dac_ready held low 50 cycles in OUT -> dac_valid, dac_err, dac_est stable for 50 cycles; no new filter_en pulse.
REQ-035 Push and pop in the same cycle at occupancy 4 (full) -> new pair accepted, occupancy stays 4, no drop.
REQ-036 Reset mid-WAIT at cycle 100 -> all outputs 0 next cycle, FIFO empty, no dac_valid pulse afterward until a new adc_valid.
REQ-037 Ordering: 4 pairs with ref=1..4 -> filter_in sequence 1,2,3,4 across successive filter_en pulses.
